oclib_memory_bist_addr_gen: RTL and testbench
=============================================

# oclib_memory_bist_addr_gen

Parametrised per-port address/command generator for the memory BIST engine. Driven from the BIST config fields (address, increment, increment mask, random mask, port shift/mask, op count, wait states, burst length). Issues a stream of burst addresses over a valid/ready handshake to one AXI master's read or write channel. One instance per enabled AXI master per direction; a done flag and issue counter feed back into BIST status.

## Interface
Parameters:
- AddressWidth, 34: width of generated address.
- PortWidth, 5: width of port index/mask (matches AXI master count width).
- CountWidth, 32: width of op count and issue counter.
- WaitWidth, 8: width of wait-state count.
- LenWidth, 4: width of burst length.

Ports:
- clock  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- go  in  1  level; start when high in IDLE, abort when low.
- port_index  in  PortWidth  this instance's AXI master number.
- address  in  AddressWidth  base address.
- address_inc  in  AddressWidth  per-op offset increment.
- address_inc_mask  in  AddressWidth  bits that receive base+offset.
- address_random_mask  in  AddressWidth  bits replaced by LFSR.
- address_port_shift  in  6  left shift of port field.
- address_port_mask  in  PortWidth  mask on port_index.
- op_count  in  CountWidth  ops to issue.
- wait_states  in  WaitWidth  idle cycles after each op.
- burst_length  in  LenWidth  burst length, passed through.
- seed  in  32  LFSR seed; zero is replaced by 1.
- addr  out  AddressWidth  generated address.
- addr_len  out  LenWidth  captured burst_length.
- addr_valid  out  1  address valid.
- addr_ready  in  1  consumer accepts.
- busy  out  1  state is RUN or WAIT.
- done  out  1  all ops issued.
- ops_issued  out  CountWidth  handshakes completed this run.

## Operation
- States: IDLE, RUN, WAIT, DONE.
- IDLE, go=1:
  - Capture all config inputs into registers.
  - Clear offset and ops_issued; load LFSR with seed (1 if zero).
  - op_count=0: go to DONE. Otherwise go to RUN.
- RUN: addr_valid=1.
  - On handshake, the op is counted: ops_issued+1, offset+=inc (mod 2^AddressWidth), LFSR steps once.
  - On handshake, next state: DONE if ops_issued reaches op_count; else WAIT if wait_states≠0; else stay in RUN.
- WAIT: addr_valid=0 for exactly wait_states cycles, then RUN.
- DONE: done=1, addr_valid=0. Hold until go=0, then IDLE with done cleared.
- Address formation:
  - base = (address & ~inc_mask) | ((address+offset) & inc_mask).
  - r = (base & ~random_mask) | (lfsr & random_mask). LFSR is zero-extended or truncated to AddressWidth.
  - addr = r | ((port_index & port_mask) << port_shift), truncated to AddressWidth.
- LFSR: 32-bit Galois, polynomial 0x80200003 (x^32+x^22+x^2+x+1), shifts right, XORs taps when LSB=1.
- Abort:
  - go=0 in WAIT: go to IDLE next cycle.
  - go=0 in RUN: addr_valid never drops without a handshake. Go to IDLE on the handshake cycle, or immediately if ready is already high.
  - done is not set on abort. ops_issued holds its value until the next start.
- Config inputs changing outside IDLE have no effect.

## Timing
- Reset: state IDLE. addr, addr_len, addr_valid, busy, done, ops_issued are all 0; LFSR=1, offset=0.
- All outputs registered.
- Start latency: go sampled high in IDLE at edge N, so addr_valid=1 with the first address after edge N+1.
- wait_states=0 with ready held high: one op per cycle, no bubbles.
- wait_states=W: W cycles with addr_valid low between beats.
- Stall (ready low): addr, addr_len, addr_valid held stable.
- Last handshake at edge M: done=1, busy=0 after edge M+1.
- op_count=0: done=1 one cycle after start; addr_valid never asserts.
- resetn low mid-run: all outputs reach reset values asynchronously.

## Structure
- Add to oclib_memory_bist_pkg:
  - state enum typedef.
  - LfsrPoly localparam (32'h80200003).
  - a function for one LFSR step.
- Optional sub-module oclib_memory_bist_lfsr: 32-bit step/load, reusable by the data generator.
- No other hierarchy.

## Test plan
- Sequential: address=0x1000, inc=0x40, inc_mask=all-ones, random=0, op_count=4, wait=0, ready=1.
  - Response: addrs 0x1000, 0x1040, 0x1080, 0x10C0 on four consecutive cycles; then done=1, ops_issued=4.
- Wait states: same config, wait=2.
  - Response: exactly 2 cycles with addr_valid low between every beat; 4 beats total.
- Mask wrap: address=0x1F0, inc=0x10, inc_mask=0xFF, op_count=2.
  - Response: addrs 0x1F0, then 0x100.
- Port/random: port_index=3, port_mask=0x1F, shift=28, random_mask=0xF, seed=1, address=0.
  - Response: first addr 0x30000001; second addr 0x30000000 | (step(1)&0xF).
- Stall/abort: ready low 5 cycles, then go dropped during the stall.
  - Response: addr_valid and addr stable throughout; on ready=1 one handshake, then IDLE with done=0 and ops_issued=1.
- Edge/reset: op_count=0 gives done one cycle after start, no valid. resetn asserted mid-RUN gives all outputs 0 immediately; restart reproduces the sequential sequence.

Source files
------------

// File: rtl/oclib_memory_bist_pkg.sv
// Shared types and LFSR helpers for the memory BIST engine.
package oclib_memory_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned LfsrWidth = 32;
    localparam logic [LfsrWidth-1:0] LfsrPoly = 32'h8020_0003;

    // One right-shifting Galois step: taps are folded in when the bit shifted out is 1.
    function automatic logic [LfsrWidth-1:0] lfsr_step(input logic [LfsrWidth-1:0] s);
        return (s >> 1) ^ (s[0] ? LfsrPoly : '0);
    endfunction

endpackage

// File: rtl/oclib_memory_bist_lfsr.sv
// 32-bit Galois LFSR with seed load and single-step advance.
module oclib_memory_bist_lfsr
    import oclib_memory_bist_pkg::*;
(
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 load,
    input  logic [LfsrWidth-1:0] seed,
    input  logic                 step,
    output logic [LfsrWidth-1:0] next_value_c
);

    logic [LfsrWidth-1:0] value;

    // An all-zero state would lock up, so a zero seed loads 1 instead.
    always_comb begin
        next_value_c = value;
        if (load) begin
            next_value_c = (seed == '0) ? LfsrWidth'(1) : seed;
        end else if (step) begin
            next_value_c = lfsr_step(value);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            value <= LfsrWidth'(1);
        end else begin
            value <= next_value_c;
        end
    end

endmodule

// File: rtl/oclib_memory_bist_addr_gen.sv
// Per-port BIST burst address generator feeding one AXI read or write address channel.
module oclib_memory_bist_addr_gen
    import oclib_memory_bist_pkg::*;
#(
    parameter int unsigned AddressWidth = 34,
    parameter int unsigned PortWidth    = 5,
    parameter int unsigned CountWidth   = 32,
    parameter int unsigned WaitWidth    = 8,
    parameter int unsigned LenWidth     = 4
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    go,
    input  logic [PortWidth-1:0]    port_index,
    input  logic [AddressWidth-1:0] address,
    input  logic [AddressWidth-1:0] address_inc,
    input  logic [AddressWidth-1:0] address_inc_mask,
    input  logic [AddressWidth-1:0] address_random_mask,
    input  logic [5:0]              address_port_shift,
    input  logic [PortWidth-1:0]    address_port_mask,
    input  logic [CountWidth-1:0]   op_count,
    input  logic [WaitWidth-1:0]    wait_states,
    input  logic [LenWidth-1:0]     burst_length,
    input  logic [31:0]             seed,
    output logic [AddressWidth-1:0] addr,
    output logic [LenWidth-1:0]     addr_len,
    output logic                    addr_valid,
    input  logic                    addr_ready,
    output logic                    busy,
    output logic                    done,
    output logic [CountWidth-1:0]   ops_issued
);

    state_t                  state, state_nx;
    logic [AddressWidth-1:0] address_r, inc_r, inc_mask_r, random_mask_r;
    logic [5:0]              port_shift_r;
    logic [PortWidth-1:0]    port_r;
    logic [CountWidth-1:0]   op_count_r;
    logic [WaitWidth-1:0]    wait_r, wait_cnt;
    logic [AddressWidth-1:0] offset, offset_nx;
    logic [AddressWidth-1:0] base_c, rand_c, addr_nx;
    logic [LfsrWidth-1:0]    lfsr_nx;
    logic                    start, handshake, last_op, valid_nx;

    assign start     = (state == ST_IDLE) && go;
    assign handshake = addr_valid && addr_ready;
    assign last_op   = (ops_issued + CountWidth'(1)) == op_count_r;

    oclib_memory_bist_lfsr u_lfsr (
        .clock        (clock),
        .resetn       (resetn),
        .load         (start),
        .seed         (seed),
        .step         (handshake),
        .next_value_c (lfsr_nx)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A beat already on the bus is never withdrawn: abort in RUN waits for its handshake.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (go) state_nx = (op_count == '0) ? ST_DONE : ST_RUN;
            ST_RUN: begin
                if (handshake) begin
                    if (!go)                  state_nx = ST_IDLE;
                    else if (last_op)         state_nx = ST_DONE;
                    else if (wait_r != '0)    state_nx = ST_WAIT;
                    else                      state_nx = ST_RUN;
                end else if (!go && !addr_valid) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!go)                  state_nx = ST_IDLE;
                else if (wait_cnt == '0)  state_nx = ST_RUN;
            end
            ST_DONE: if (!go) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Address for the beat that will be presented after this edge.
    always_comb begin
        offset_nx = offset;
        if (start) begin
            offset_nx = '0;
        end else if (handshake) begin
            offset_nx = offset + inc_r;
        end
        base_c   = (address_r & ~inc_mask_r) | ((address_r + offset_nx) & inc_mask_r);
        rand_c   = (base_c & ~random_mask_r) | (AddressWidth'(lfsr_nx) & random_mask_r);
        addr_nx  = rand_c | (AddressWidth'(port_r) << port_shift_r);
        valid_nx = (state_nx == ST_RUN) && (state != ST_IDLE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            address_r     <= '0;
            inc_r         <= '0;
            inc_mask_r    <= '0;
            random_mask_r <= '0;
            port_shift_r  <= '0;
            port_r        <= '0;
            op_count_r    <= '0;
            wait_r        <= '0;
            wait_cnt      <= '0;
            offset        <= '0;
            addr          <= '0;
            addr_len      <= '0;
            addr_valid    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ops_issued    <= '0;
        end else begin
            offset <= offset_nx;
            if (start) begin
                address_r     <= address;
                inc_r         <= address_inc;
                inc_mask_r    <= address_inc_mask;
                random_mask_r <= address_random_mask;
                port_shift_r  <= address_port_shift;
                port_r        <= port_index & address_port_mask;
                op_count_r    <= op_count;
                wait_r        <= wait_states;
                addr_len      <= burst_length;
                ops_issued    <= '0;
            end else if (handshake) begin
                ops_issued <= ops_issued + CountWidth'(1);
            end
            if ((state == ST_RUN) && (state_nx == ST_WAIT)) begin
                wait_cnt <= wait_r - WaitWidth'(1);
            end else if (wait_cnt != '0) begin
                wait_cnt <= wait_cnt - WaitWidth'(1);
            end
            addr_valid <= valid_nx;
            if (valid_nx) begin
                addr <= addr_nx;
            end
            busy <= (state == ST_RUN) || (state == ST_WAIT);
            done <= (state == ST_DONE);
        end
    end

endmodule

// File: tb/tb_oclib_memory_bist_addr_gen.sv
// Directed bench for oclib_memory_bist_addr_gen with an address-list model and per-cycle checker.
module tb_oclib_memory_bist_addr_gen;

    localparam int unsigned AW = 34;
    localparam int unsigned PW = 5;
    localparam int unsigned CW = 32;
    localparam int unsigned WW = 8;
    localparam int unsigned LW = 4;

    logic          clock;
    logic          resetn;
    logic          go;
    logic [PW-1:0] port_index;
    logic [AW-1:0] address;
    logic [AW-1:0] address_inc;
    logic [AW-1:0] address_inc_mask;
    logic [AW-1:0] address_random_mask;
    logic [5:0]    address_port_shift;
    logic [PW-1:0] address_port_mask;
    logic [CW-1:0] op_count;
    logic [WW-1:0] wait_states;
    logic [LW-1:0] burst_length;
    logic [31:0]   seed;
    logic [AW-1:0] addr;
    logic [LW-1:0] addr_len;
    logic          addr_valid;
    logic          addr_ready;
    logic          busy;
    logic          done;
    logic [CW-1:0] ops_issued;

    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    logic [AW-1:0] exp_q[$];
    int            beat_cyc[$];
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    oclib_memory_bist_addr_gen dut (
        .clock               (clock),
        .resetn              (resetn),
        .go                  (go),
        .port_index          (port_index),
        .address             (address),
        .address_inc         (address_inc),
        .address_inc_mask    (address_inc_mask),
        .address_random_mask (address_random_mask),
        .address_port_shift  (address_port_shift),
        .address_port_mask   (address_port_mask),
        .op_count            (op_count),
        .wait_states         (wait_states),
        .burst_length        (burst_length),
        .seed                (seed),
        .addr                (addr),
        .addr_len            (addr_len),
        .addr_valid          (addr_valid),
        .addr_ready          (addr_ready),
        .busy                (busy),
        .done                (done),
        .ops_issued          (ops_issued)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Galois LFSR step written from the polynomial definition.
    function automatic logic [31:0] m_step(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    // Address of op i, from the configuration currently on the inputs.
    function automatic logic [AW-1:0] model_addr(input int i);
        logic [63:0]   prod;
        logic [AW-1:0] off, sum, base, rnd;
        logic [31:0]   s;
        prod = 64'(address_inc) * 64'(i);
        off  = prod[AW-1:0];
        sum  = address + off;
        base = (address & ~address_inc_mask) | (sum & address_inc_mask);
        s = (seed == 32'd0) ? 32'd1 : seed;
        for (int k = 0; k < i; k++) s = m_step(s);
        rnd = (base & ~address_random_mask) | (AW'(s) & address_random_mask);
        return rnd | (AW'(port_index & address_port_mask) << address_port_shift);
    endfunction

    // Every presented beat must be the next expected address; stalls must hold addr steady.
    always @(negedge clock) begin
        if (resetn) begin
            if (prev_stall) begin
                chk("stall_valid", 64'(addr_valid), 64'd1);
                chk("stall_addr", 64'(addr), 64'(prev_addr));
            end
            if (addr_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 64'(addr), 64'hDEAD);
                end else begin
                    chk("addr", 64'(addr), 64'(exp_q[0]));
                    chk("addr_len", 64'(addr_len), 64'(burst_length));
                end
                if (addr_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    beat_cyc.push_back(cyc);
                end
            end
            prev_stall = addr_valid && !addr_ready;
            prev_addr  = addr;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            step(1);
            n++;
        end
        chk("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic set_cfg(input logic [AW-1:0] a, input logic [AW-1:0] inc,
                           input logic [AW-1:0] imask, input logic [AW-1:0] rmask,
                           input logic [PW-1:0] pidx, input logic [PW-1:0] pmask,
                           input logic [5:0] sh, input logic [CW-1:0] n,
                           input logic [WW-1:0] ws, input logic [LW-1:0] bl,
                           input logic [31:0] sd);
        address = a; address_inc = inc; address_inc_mask = imask;
        address_random_mask = rmask; port_index = pidx; address_port_mask = pmask;
        address_port_shift = sh; op_count = n; wait_states = ws;
        burst_length = bl; seed = sd;
    endtask

    task automatic push_seq();
        exp_q.push_back(34'h1000);
        exp_q.push_back(34'h1040);
        exp_q.push_back(34'h1080);
        exp_q.push_back(34'h10C0);
    endtask

    initial begin
        resetn = 1'b0; go = 1'b0; addr_ready = 1'b1;
        set_cfg('0, '0, '0, '0, '0, '0, 6'd0, '0, '0, '0, 32'd0);
        step(3);
        // Reset state
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_len", 64'(addr_len), 64'd0);
        chk("rst_valid", 64'(addr_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ops", 64'(ops_issued), 64'd0);
        resetn = 1'b1;
        step(2);

        // Sequential, back-to-back
        set_cfg(34'h1000, 34'h40, {AW{1'b1}}, '0, '0, '0, 6'd0, 32'd4, 8'd0, 4'h7, 32'd1);
        chk("model_seq3", 64'(model_addr(3)), 64'h10C0);
        push_seq();
        go = 1'b1;
        step(1);
        chk("seq_lat_valid0", 64'(addr_valid), 64'd0);
        step(1);
        chk("seq_first_valid", 64'(addr_valid), 64'd1);
        chk("seq_first_addr", 64'(addr), 64'h1000);
        chk("seq_busy", 64'(busy), 64'd1);
        step(4);
        chk("seq_valid_off", 64'(addr_valid), 64'd0);
        chk("seq_done_early", 64'(done), 64'd0);
        step(1);
        chk("seq_done", 64'(done), 64'd1);
        chk("seq_busy_off", 64'(busy), 64'd0);
        chk("seq_ops", 64'(ops_issued), 64'd4);
        chk("seq_drained", 64'(exp_q.size()), 64'd0);
        go = 1'b0;
        step(2);
        chk("seq_done_clr", 64'(done), 64'd0);

        // Wait states: two dead cycles between beats
        wait_states = 8'd2;
        for (int i = 0; i < 4; i++) exp_q.push_back(model_addr(i));
        beat_cyc.delete();
        go = 1'b1;
        wait_done(100);
        chk("wait_beats", 64'(beat_cyc.size()), 64'd4);
        for (int i = 0; i + 1 < beat_cyc.size(); i++)
            chk("wait_gap", 64'(beat_cyc[i+1] - beat_cyc[i]), 64'd3);
        chk("wait_ops", 64'(ops_issued), 64'd4);
        go = 1'b0;
        step(2);

        // Increment confined to the masked low byte
        set_cfg(34'h1F0, 34'h10, 34'hFF, '0, '0, '0, 6'd0, 32'd2, 8'd0, 4'h3, 32'd1);
        chk("model_wrap1", 64'(model_addr(1)), 64'h100);
        exp_q.push_back(34'h1F0);
        exp_q.push_back(34'h100);
        go = 1'b1;
        wait_done(50);
        chk("wrap_drained", 64'(exp_q.size()), 64'd0);
        chk("wrap_ops", 64'(ops_issued), 64'd2);
        go = 1'b0;
        step(2);

        // Port field plus LFSR nibble, seed 1 and seed 0 behave alike
        for (int s = 1; s >= 0; s--) begin
            set_cfg('0, '0, {AW{1'b1}}, 34'hF, 5'd3, 5'h1F, 6'd28, 32'd2, 8'd0, 4'h1, 32'(s));
            chk("model_port1", 64'(model_addr(1)), 64'h3000_0003);
            exp_q.push_back(34'h3000_0001);
            exp_q.push_back(34'h3000_0003);
            go = 1'b1;
            wait_done(50);
            chk("port_drained", 64'(exp_q.size()), 64'd0);
            go = 1'b0;
            step(2);
        end

        // Stall then abort during the stall
        set_cfg(34'h1000, 34'h40, {AW{1'b1}}, '0, '0, '0, 6'd0, 32'd4, 8'd0, 4'h2, 32'd1);
        exp_q.push_back(34'h1000);
        addr_ready = 1'b0;
        go = 1'b1;
        step(2);
        chk("stall_first", 64'(addr), 64'h1000);
        step(3);
        go = 1'b0;
        step(2);
        chk("stall_hold", 64'(addr_valid), 64'd1);
        addr_ready = 1'b1;
        step(1);
        chk("abort_valid", 64'(addr_valid), 64'd0);
        step(1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_ops", 64'(ops_issued), 64'd1);
        chk("abort_drained", 64'(exp_q.size()), 64'd0);
        step(2);

        // Zero op count: done without any beat
        op_count = 32'd0;
        go = 1'b1;
        step(1);
        chk("zero_done_lat", 64'(done), 64'd0);
        step(1);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_valid", 64'(addr_valid), 64'd0);
        go = 1'b0;
        step(2);

        // Reset mid-run, then restart
        op_count = 32'd4;
        push_seq();
        go = 1'b1;
        step(3);
        chk("mid_valid", 64'(addr_valid), 64'd1);
        resetn = 1'b0;
        #1;
        chk("arst_addr", 64'(addr), 64'd0);
        chk("arst_len", 64'(addr_len), 64'd0);
        chk("arst_valid", 64'(addr_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_ops", 64'(ops_issued), 64'd0);
        exp_q.delete();
        go = 1'b0;
        step(2);
        resetn = 1'b1;
        step(1);
        push_seq();
        go = 1'b1;
        wait_done(50);
        chk("restart_ops", 64'(ops_issued), 64'd4);
        chk("restart_drained", 64'(exp_q.size()), 64'd0);
        go = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule
